// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if
// Bundles the requester side and the I2C sender side of the command arbiter.
//   i_req[NUM_REQ]        request level per requester
//   i_data[24*NUM_REQ]    frame per requester, requester k at [24k+23:24k]
//   o_grant[NUM_REQ]      one-cycle pulse, frame of that requester latched
//   o_done[NUM_REQ]       one-cycle pulse, frame of that requester completed
//   o_error[NUM_REQ]      one-cycle pulse, frame of that requester timed out
//   o_busy                high while the arbiter is not idle
//   o_send_start          start level to the I2C sender
//   o_send_data[24]       frame to the I2C sender
//   i_send_finished       one-cycle finish pulse from the I2C sender
// slave modport: arbiter side. master modport: requesters + sender side.
interface i2c_cmd_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    i_req;
    logic [24*NUM_REQ-1:0] i_data;
    logic [NUM_REQ-1:0]    o_grant;
    logic [NUM_REQ-1:0]    o_done;
    logic [NUM_REQ-1:0]    o_error;
    logic                  o_busy;
    logic                  o_send_start;
    logic [23:0]           o_send_data;
    logic                  i_send_finished;

    modport slave (
        input  i_req, i_data, i_send_finished,
        output o_grant, o_done, o_error, o_busy, o_send_start, o_send_data
    );

    modport master (
        output i_req, i_data, i_send_finished,
        input  o_grant, o_done, o_error, o_busy, o_send_start, o_send_data
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
// Round-robin arbiter sharing one WM8731 I2C sender between NUM_REQ (2..4)
// command sources. One frame at a time: grant, hold start until the sender's
// finish pulse, then one GAP cycle with start low before returning to IDLE.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  synchronous active-low reset
//   bus      i2c_cmd_arbiter_if.slave (requests, frames, grant/done/error
//            pulses, busy, sender start/data/finished)
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a 16-bit watchdog that
// ends a frame with o_error after TIMEOUT_CYCLES BUSY cycles. Without it
// o_error is tied to 0 and BUSY waits indefinitely.
module i2c_cmd_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic              i_clk,
    input logic              i_rst_n,
    i2c_cmd_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic [23:0]        data_q, data_d;

    logic [23:0] req_data [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_data[g] = bus.i_data[24*g +: 24];
    end

    // First requesting index at or after ptr, wrapping.
    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    always_comb begin
        int unsigned     idx;
        logic [IdxW-1:0] idx_w;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_w      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx   = (32'(ptr_q) + i) % NUM_REQ;
            idx_w = IdxW'(idx);
            if (!pick_valid && bus.i_req[idx_w]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_w;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]        wdog_q, wdog_d;
    logic [NUM_REQ-1:0] error_q, error_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = '0;
        done_d  = '0;
        start_d = start_q;
        data_d  = data_q;
`ifdef I2C_ARB_TIMEOUT_EN
        error_d = '0;
        wdog_d  = wdog_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d           = pick_idx;
                    data_d            = req_data[pick_idx];
                    grant_d[pick_idx] = 1'b1;
                    start_d           = 1'b1;
                    ptr_d             = IdxW'((32'(pick_idx) + 32'd1) % NUM_REQ);
                    state_d           = StBusy;
`ifdef I2C_ARB_TIMEOUT_EN
                    wdog_d            = '0;
`endif
                end
            end
            StBusy: begin
`ifdef I2C_ARB_TIMEOUT_EN
                wdog_d = wdog_q + 16'd1;
`endif
                // Finish takes priority over a simultaneous timeout.
                if (bus.i_send_finished) begin
                    done_d[owner_q] = 1'b1;
                    start_d         = 1'b0;
                    state_d         = StGap;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (wdog_q == WdogLast) begin
                    error_d[owner_q] = 1'b1;
                    start_d          = 1'b0;
                    state_d          = StGap;
                end
`endif
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            error_q <= '0;
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            data_q  <= data_d;
`ifdef I2C_ARB_TIMEOUT_EN
            error_q <= error_d;
            wdog_q  <= wdog_d;
`endif
        end
    end

    assign bus.o_grant      = grant_q;
    assign bus.o_done       = done_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_send_start = start_q;
    assign bus.o_send_data  = data_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign bus.o_error      = error_q;
`else
    assign bus.o_error      = '0;
`endif
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
`timescale 1ns/1ps
module tb_i2c_cmd_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_cmd_arbiter_if #(.NUM_REQ(N)) bus ();

    i2c_cmd_arbiter #(
        .NUM_REQ       (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;   // model: next index to search from
    int owner;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after p, wrapping modulo N.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] outs();
        return {27'd0, bus.o_grant, bus.o_done, bus.o_error, bus.o_busy, bus.o_send_start,
                bus.o_send_data};
    endfunction

    // One frame from the IDLE state: grant, lat cycles of start, done, GAP, IDLE.
    task automatic serve(input int lat, input bit keep, input bit spur_gap, output int who);
        logic [23:0]  exp_data;
        logic [N-1:0] oh;
        who = pick(bus.i_req, m_ptr);
        if (who < 0) begin
            check("no_request", 64'(bus.i_req), 64'd1);
            return;
        end
        exp_data = bus.i_data[24*who +: 24];
        oh       = N'(1) << who;
        tick();
        check("grant", {bus.o_grant, bus.o_busy, bus.o_send_start, bus.o_send_data},
              {oh, 1'b1, 1'b1, exp_data});
        m_ptr = (who + 1) % N;
        if (!keep) bus.i_req[who] = 1'b0;
        for (int i = 1; i < lat; i++) begin
            tick();
            check("start_hold", {bus.o_grant, bus.o_done, bus.o_error, bus.o_send_start,
                  bus.o_send_data}, {N'(0), N'(0), N'(0), 1'b1, exp_data});
        end
        bus.i_send_finished = 1'b1;
        tick();
        bus.i_send_finished = 1'b0;
        check("done", {bus.o_grant, bus.o_done, bus.o_error, bus.o_busy, bus.o_send_start},
              {N'(0), oh, N'(0), 1'b1, 1'b0});
        if (spur_gap) bus.i_send_finished = 1'b1;
        tick();
        bus.i_send_finished = 1'b0;
        check("idle_after_gap", {bus.o_grant, bus.o_done, bus.o_error, bus.o_busy,
              bus.o_send_start}, '0);
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic serve_timeout();
        int           who;
        logic [N-1:0] oh;
        who = pick(bus.i_req, m_ptr);
        oh  = N'(1) << who;
        tick();
        check("to_grant", 64'(bus.o_grant), 64'(oh));
        m_ptr = (who + 1) % N;
        bus.i_req[who] = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            check("to_wait", {bus.o_error, bus.o_done, bus.o_send_start},
                  {N'(0), N'(0), 1'b1});
        end
        tick();
        check("to_error", {bus.o_grant, bus.o_done, bus.o_error, bus.o_busy, bus.o_send_start},
              {N'(0), N'(0), oh, 1'b1, 1'b0});
        tick();
        check("to_idle", {bus.o_error, bus.o_busy, bus.o_send_start}, '0);
    endtask
`endif

    initial begin
        #200us;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.i_req           = '0;
        bus.i_data          = '0;
        bus.i_send_finished = 1'b0;
        tick();
        tick();
        check("reset_state", outs(), '0);
        rst_n = 1'b1;

        // Single request
        bus.i_data[23:0] = 24'h340C00;
        bus.i_req[0]     = 1'b1;
        serve(30, 1'b0, 1'b0, owner);
        check("single_owner", 64'(owner), 64'd0);

        // Spurious finish in IDLE
        bus.i_send_finished = 1'b1;
        tick();
        bus.i_send_finished = 1'b0;
        check("spurious_idle", outs() & 64'hFFFF_FF00_0000_0000 | {40'd0, 24'd0}, '0);
        tick();
        check("spurious_idle2", {bus.o_done, bus.o_busy, bus.o_send_start}, '0);

        // Reset during BUSY
        bus.i_data[47:24] = 24'hABCDEF;
        bus.i_req[1]      = 1'b1;
        tick();
        bus.i_req[1] = 1'b0;
        tick();
        check("busy_before_reset", {bus.o_busy, bus.o_send_start}, 2'b11);
        rst_n = 1'b0;
        tick();
        check("reset_mid_frame", outs(), '0);
        rst_n = 1'b1;
        m_ptr = 0;

        // Fairness with req0/req1 held, spurious finish in GAP on each frame
        bus.i_data[23:0]  = 24'h1A0001;
        bus.i_data[47:24] = 24'h1A0102;
        bus.i_req[1:0]    = 2'b11;
        for (int f = 0; f < 4; f++) begin
            serve(3 + f, 1'b1, 1'b1, owner);
            check("rr_order", 64'(owner), 64'(f % 2));
        end
        bus.i_req = '0;

        // Pointer wrap
        bus.i_data[95:72] = 24'h3C3C3C;
        bus.i_req[3]      = 1'b1;
        serve(2, 1'b0, 1'b0, owner);
        check("wrap_first", 64'(owner), 64'd3);
        bus.i_req[0] = 1'b1;
        bus.i_req[3] = 1'b1;
        serve(2, 1'b0, 1'b0, owner);
        check("wrap_second", 64'(owner), 64'd0);
        serve(2, 1'b0, 1'b0, owner);
        check("wrap_third", 64'(owner), 64'd3);

`ifdef I2C_ARB_TIMEOUT_EN
        bus.i_data[71:48] = 24'h22_0000;
        bus.i_data[95:72] = 24'h33_0000;
        bus.i_req[3:2]    = 2'b11;
        serve_timeout();
        serve(5, 1'b0, 1'b0, owner);
        bus.i_req[1] = 1'b1;
        serve(TO, 1'b0, 1'b0, owner);
`endif

        // Randomized traffic against the round-robin model
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < N; k++) begin
                if (!bus.i_req[k] && $urandom_range(1, 0) == 1) begin
                    bus.i_data[24*k +: 24] = 24'($urandom);
                    bus.i_req[k]           = 1'b1;
                end
            end
            if (bus.i_req == '0) begin
                bus.i_req[$urandom_range(N - 1, 0)] = 1'b1;
            end
            serve(int'($urandom_range(6, 1)), 1'b0, 1'($urandom_range(1, 0)), owner);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
